// File: rtl/bram_copy_engine.sv
// rtl/bram_copy_engine.sv - block copy initiator for a 1024x16 true dual-port BRAM
// Reads on port A and writes on port B one word per clock, picking direction so overlapping moves are safe.
module bram_copy_engine #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          wrena,
  output logic          rdena,
  output logic [AW-1:0] addra,
  output logic [DW-1:0] dina,
  input  logic [DW-1:0] douta,
  output logic          wrenb,
  output logic          rdenb,
  output logic [AW-1:0] addrb,
  output logic [DW-1:0] dinb,
  input  logic [DW-1:0] doutb
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [AW:0] ZERO    = '0;
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  state_t        state;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW:0]   len_q;
  logic [AW:0]   cnt;
  logic          desc;

  logic [AW:0]   src_end;
  logic          dir_desc;
  logic          unused_doutb;

  // Overlap test uses unwrapped sums so a destination just past the source end is not mistaken for overlap.
  assign src_end  = {1'b0, src_addr} + len;
  assign dir_desc = (dst_addr > src_addr) && ({1'b0, dst_addr} < src_end);

  assign wrena        = 1'b0;
  assign rdenb        = 1'b0;
  assign dina         = '0;
  assign dinb         = douta;
  assign unused_doutb = ^doutb;

  function automatic logic [AW-1:0] step_addr(input logic [AW-1:0] base, input logic d,
                                              input logic [AW:0] n, input logic [AW:0] k);
    logic [AW:0] off;
    off = d ? (n - ONE - k) : k;
    return base + off[AW-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      rdena <= 1'b0;
      wrenb <= 1'b0;
      addra <= '0;
      addrb <= '0;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      cnt   <= '0;
      desc  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= len;
            desc  <= dir_desc;
            if (len > MAX_LEN) begin
              err <= 1'b1;
            end else if (len == ZERO) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
              busy  <= 1'b1;
              rdena <= 1'b1;
              addra <= step_addr(src_addr, dir_desc, len, ZERO);
              cnt   <= ONE;
            end
          end
        end
        // cnt counts reads already issued; each cycle writes the word read one cycle earlier.
        READ: begin
          wrenb <= 1'b1;
          addrb <= step_addr(dst_q, desc, len_q, cnt - ONE);
          if (cnt == len_q) begin
            state <= DRAIN;
            rdena <= 1'b0;
          end else begin
            addra <= step_addr(src_q, desc, len_q, cnt);
            cnt   <= cnt + ONE;
          end
        end
        DRAIN: begin
          state <= DONE;
          wrenb <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_copy_engine.sv
// tb/tb_bram_copy_engine.sv - self-checking bench for bram_copy_engine with a behavioural BRAM and copy model
// The model copies word by word in the direction chosen from the start arguments.
module tb_bram_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  src_addr;
  logic [9:0]  dst_addr;
  logic [10:0] len;
  logic        busy, done, err;
  logic        wrena, rdena, wrenb, rdenb;
  logic [9:0]  addra, addrb;
  logic [15:0] dina, douta, dinb, doutb;

  logic [15:0] mem     [1024];
  logic [15:0] ref_mem [1024];

  int errors = 0;
  int checks = 0;

  int  cyc = 0;
  bit  cap = 0;
  bit  start_seen;
  int  start_cyc, done_cyc;
  int  busy_cnt, done_cnt, err_cnt;
  int  rd_q[$];
  int  wr_q[$];

  always #5 clk = ~clk;

  bram_copy_engine #(.AW(10), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .wrena(wrena), .rdena(rdena), .addra(addra), .dina(dina), .douta(douta),
    .wrenb(wrenb), .rdenb(rdenb), .addrb(addrb), .dinb(dinb), .doutb(doutb)
  );

  assign doutb = 16'h0000;

  // Read-first BRAM: douta is valid the cycle after the read edge.
  always @(posedge clk) begin
    if (rdena) douta <= mem[addra];
    if (wrenb) mem[addrb] <= dinb;
  end

  always @(negedge clk) begin
    cyc++;
    if (cap) begin
      if (start && !start_seen) begin
        start_seen = 1;
        start_cyc  = cyc;
      end
      if (rdena) rd_q.push_back(int'(addra));
      if (wrenb) wr_q.push_back(int'(addrb));
      if (busy) busy_cnt++;
      if (err) err_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_copy(input string tag, input int s, input int d, input int n, input bit mid_start);
    int  exp_rd[$];
    int  exp_wr[$];
    int  nv, off, mis, exp_done;
    bit  dsc;
    nv  = (n >= 1 && n <= 1024) ? n : 0;
    dsc = (d > s) && (d < s + n);
    for (int k = 0; k < nv; k++) begin
      off = dsc ? (n - 1 - k) : k;
      exp_rd.push_back((s + off) % 1024);
      exp_wr.push_back((d + off) % 1024);
    end
    for (int k = 0; k < nv; k++) ref_mem[exp_wr[k]] = ref_mem[exp_rd[k]];
    exp_done = (n == 0) ? 1 : (n + 2);

    rd_q.delete();
    wr_q.delete();
    start_seen = 0;
    start_cyc  = 0;
    done_cyc   = -1;
    busy_cnt   = 0;
    done_cnt   = 0;
    err_cnt    = 0;
    cap        = 1;

    @(posedge clk); #1;
    src_addr = s[9:0];
    dst_addr = d[9:0];
    len      = n[10:0];
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    src_addr = 10'($urandom);
    dst_addr = 10'($urandom);
    len      = 11'($urandom);
    if (mid_start) begin
      repeat (2) @(posedge clk);
      #1;
      start    = 1'b1;
      src_addr = 10'($urandom);
      dst_addr = 10'($urandom);
      len      = 11'($urandom_range(1, 20));
      @(posedge clk); #1;
      start    = 1'b0;
    end
    repeat (nv + 6) @(posedge clk);
    #1;
    cap = 0;

    check({tag, ".rd_count"}, rd_q.size(), exp_rd.size());
    mis = 0;
    for (int k = 0; k < rd_q.size() && k < exp_rd.size(); k++) if (rd_q[k] != exp_rd[k]) mis++;
    check({tag, ".rd_seq_mismatches"}, mis, 0);
    check({tag, ".wr_count"}, wr_q.size(), exp_wr.size());
    mis = 0;
    for (int k = 0; k < wr_q.size() && k < exp_wr.size(); k++) if (wr_q[k] != exp_wr[k]) mis++;
    check({tag, ".wr_seq_mismatches"}, mis, 0);
    check({tag, ".busy_cycles"}, busy_cnt, (nv > 0) ? nv + 1 : 0);
    check({tag, ".done_pulses"}, done_cnt, (n <= 1024) ? 1 : 0);
    check({tag, ".err_pulses"}, err_cnt, (n > 1024) ? 1 : 0);
    if (n <= 1024) check({tag, ".done_latency"}, done_cyc - start_cyc, exp_done);
    mis = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mis++;
    check({tag, ".mem_mismatches"}, mis, 0);
  endtask

  initial begin
    int s, d, n;
    rst_n    = 1'b0;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len      = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset.busy",  int'(busy),  0);
    check("reset.done",  int'(done),  0);
    check("reset.err",   int'(err),   0);
    check("reset.rdena", int'(rdena), 0);
    check("reset.wrenb", int'(wrenb), 0);
    check("reset.addra", int'(addra), 0);
    check("reset.addrb", int'(addrb), 0);
    check("reset.tieoffs", int'({wrena, rdenb, dina}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      mem[16 + i]     = 16'((i + 1) * 16'h0011);
      ref_mem[16 + i] = mem[16 + i];
    end
    do_copy("basic", 16'h010, 16'h100, 4, 0);
    check("basic.word3", int'(mem[16'h103]), 16'h0044);

    mem[5] = 16'h00AA; mem[6] = 16'h00BB; mem[7] = 16'h00CC;
    ref_mem[5] = mem[5]; ref_mem[6] = mem[6]; ref_mem[7] = mem[7];
    do_copy("overlap", 5, 6, 3, 0);
    check("overlap.ram5", int'(mem[5]), 16'h00AA);
    check("overlap.ram6", int'(mem[6]), 16'h00AA);
    check("overlap.ram8", int'(mem[8]), 16'h00CC);

    do_copy("wrap",     16'h3FE, 16'h000, 4,    0);
    do_copy("len0",     50,      60,      0,    0);
    do_copy("len1025",  50,      60,      1025, 0);
    do_copy("len1",     900,     3,       1,    0);
    do_copy("midstart", 200,     400,     8,    1);

    // Asynchronous reset while read k=2 of an 8-word copy is on the bus.
    @(posedge clk); #1;
    src_addr = 10'd600;
    dst_addr = 10'd700;
    len      = 11'd8;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midreset.pre_rdena", int'(rdena), 1);
    check("midreset.pre_addra", int'(addra), 602);
    rst_n = 1'b0;
    #1;
    check("midreset.outputs", int'({busy, done, err, rdena, wrenb}), 0);
    check("midreset.addra", int'(addra), 0);
    check("midreset.addrb", int'(addrb), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_copy("after_reset", 600, 700, 8, 0);

    do_copy("full1024", 100, 300, 1024, 0);
    for (int t = 0; t < 10; t++) begin
      s = int'($urandom_range(0, 1023));
      n = int'($urandom_range(1, 64));
      do begin
        d = int'($urandom_range(0, 1023));
      end while (((d - s + 1024) % 1024) == 1 || ((d - s + 1024) % 1024) == 1023);
      do_copy($sformatf("rand%0d", t), s, d, n, 0);
    end
    do_copy("rand_err", 10, 20, int'($urandom_range(1025, 2047)), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
